prf_timing_ctrl: RTL and testbench

Pulse-repetition timing controller for the radar receive chain. It sequences one coherent processing interval (CPI) of `PRF_N` pulse repetition periods (PRTs). In each PRT it gates the IF LFM transmit generator, blanks, then opens a receive window that qualifies DDC and pulse-compression outputs. It runs in the 120 MHz datapath domain and replaces free-running echo generation with a deterministic, per-pulse-indexed schedule.

---
 rtl/prf_timing_ctrl.sv | 116 +++++++++++
 tb/tb_prf_timing_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/prf_timing_ctrl.sv
// Pulse-repetition timing controller: sequences PRF_N PRTs per CPI, gating TX,
// blanking, and opening a receive window with a per-sample range bin.
module prf_timing_ctrl #(
  parameter int PRF_N     = 10,
  parameter int PRT_CYC   = 12000,
  parameter int TX_CYC    = 1200,
  parameter int BLANK_CYC = 120,
  parameter int RX_CYC    = 9600,
  parameter int CNT_W     = 16,
  parameter int IDX_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             abort,
  output logic             busy,
  output logic             tx_en,
  output logic             rx_gate,
  output logic             prt_start,
  output logic             cpi_done,
  output logic [IDX_W-1:0] pulse_idx,
  output logic [CNT_W-1:0] range_bin
);

  localparam logic [CNT_W-1:0] TX_LAST    = CNT_W'(TX_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(TX_CYC + BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] RX_LAST    = CNT_W'(TX_CYC + BLANK_CYC + RX_CYC - 1);
  localparam logic [CNT_W-1:0] PRT_LAST   = CNT_W'(PRT_CYC - 1);
  localparam logic [CNT_W-1:0] RX_OFF     = CNT_W'(TX_CYC + BLANK_CYC);
  localparam logic [CNT_W-1:0] CYC_ONE    = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(PRF_N - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  typedef enum logic [2:0] {IDLE, TX, BLANK, RX, WAIT} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cyc, cyc_nx;
  logic [IDX_W-1:0] idx, idx_nx;

  logic             busy_d, tx_d, rx_d, prt_d, done_d;
  logic [CNT_W-1:0] rb_d;

  // Outputs are registered from the next-state values so they line up with state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cyc       <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      tx_en     <= 1'b0;
      rx_gate   <= 1'b0;
      prt_start <= 1'b0;
      cpi_done  <= 1'b0;
      range_bin <= '0;
    end else begin
      state     <= state_nx;
      cyc       <= cyc_nx;
      idx       <= idx_nx;
      busy      <= busy_d;
      tx_en     <= tx_d;
      rx_gate   <= rx_d;
      prt_start <= prt_d;
      cpi_done  <= done_d;
      range_bin <= rb_d;
    end
  end

  assign pulse_idx = idx;

  always_comb begin
    state_nx = state;
    cyc_nx   = cyc;
    idx_nx   = idx;
    if (abort) begin
      state_nx = IDLE;
      cyc_nx   = '0;
      idx_nx   = '0;
    end else if (state == IDLE) begin
      if (start) begin
        state_nx = TX;
        cyc_nx   = '0;
        idx_nx   = '0;
      end
    end else if (cyc == PRT_LAST) begin
      // End of PRT takes precedence, which also covers a receive window ending on the last cycle.
      cyc_nx = '0;
      if (idx != IDX_LAST) begin
        state_nx = TX;
        idx_nx   = idx + IDX_ONE;
      end else begin
        state_nx = cont ? TX : IDLE;
        idx_nx   = '0;
      end
    end else begin
      cyc_nx = cyc + CYC_ONE;
      case (state)
        TX:      if (cyc == TX_LAST)    state_nx = BLANK;
        BLANK:   if (cyc == BLANK_LAST) state_nx = RX;
        RX:      if (cyc == RX_LAST)    state_nx = WAIT;
        WAIT:    state_nx = WAIT;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_d = (state_nx != IDLE);
    tx_d   = (state_nx == TX);
    rx_d   = (state_nx == RX);
    prt_d  = (state_nx == TX) && (cyc_nx == '0);
    done_d = (state_nx != IDLE) && (cyc_nx == PRT_LAST) && (idx_nx == IDX_LAST);
    rb_d   = rx_d ? (cyc_nx - RX_OFF) : '0;
  end

endmodule

// File: tb/tb_prf_timing_ctrl.sv
// Bench for prf_timing_ctrl: nominal (RX=10) and back-to-back window (RX=14) instances
// driven in lockstep, checked against a timeline model and a single-CPI checkpoint table.
module tb_prf_timing_ctrl;

  typedef struct packed {
    logic        busy;
    logic        tx;
    logic        rx;
    logic        ps;
    logic        done;
    logic [7:0]  idx;
    logic [15:0] rb;
  } out_t;

  typedef struct {
    int   cyc;
    out_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst, start, cont, abort;

  logic        busy0, tx0, rx0, ps0, done0;
  logic [7:0]  idx0;
  logic [15:0] rb0;
  logic        busy1, tx1, rx1, ps1, done1;
  logic [7:0]  idx1;
  logic [15:0] rb1;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  out_t q0[$];
  out_t q1[$];
  out_t log0[0:63];
  vec_t tbl[16];

  always #5 clk = ~clk;

  prf_timing_ctrl #(.PRF_N(3), .PRT_CYC(20), .TX_CYC(4), .BLANK_CYC(2), .RX_CYC(10),
                    .CNT_W(16), .IDX_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
    .busy(busy0), .tx_en(tx0), .rx_gate(rx0), .prt_start(ps0), .cpi_done(done0),
    .pulse_idx(idx0), .range_bin(rb0));

  prf_timing_ctrl #(.PRF_N(3), .PRT_CYC(20), .TX_CYC(4), .BLANK_CYC(2), .RX_CYC(14),
                    .CNT_W(16), .IDX_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
    .busy(busy1), .tx_en(tx1), .rx_gate(rx1), .prt_start(ps1), .cpi_done(done1),
    .pulse_idx(idx1), .range_bin(rb1));

  // Expected outputs t cycles after the first prt_start of a run (period 20, 3 PRTs per CPI).
  function automatic out_t model(input bit act, input int t, input int rxc);
    out_t o;
    int   c, p;
    o = '0;
    if (act) begin
      c      = t % 20;
      p      = t / 20;
      o.busy = 1'b1;
      o.tx   = (c < 4);
      o.rx   = (c >= 6) && (c < 6 + rxc);
      o.rb   = o.rx ? 16'(c - 6) : 16'd0;
      o.ps   = (c == 0);
      o.idx  = 8'(p % 3);
      o.done = (c == 19) && ((p % 3) == 2);
    end
    return o;
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got busy=%b tx=%b rx=%b ps=%b done=%b idx=%0d rb=%0d want busy=%b tx=%b rx=%b ps=%b done=%b idx=%0d rb=%0d",
                  name, got.busy, got.tx, got.rx, got.ps, got.done, got.idx, got.rb,
                  exp.busy, exp.tx, exp.rx, exp.ps, exp.done, exp.idx, exp.rb);
  endtask

  // Drive one cycle of inputs, queue the expected next-cycle outputs, then compare after the edge.
  task automatic step(input string name, input logic r, input logic s, input logic c,
                      input logic a, input bit act, input int t, input int log_idx);
    out_t e0, e1, g0, g1;
    rst = r; start = s; cont = c; abort = a;
    q0.push_back(model(act, t, 10));
    q1.push_back(model(act, t, 14));
    @(posedge clk);
    #1;
    g0 = '{busy0, tx0, rx0, ps0, done0, idx0, rb0};
    g1 = '{busy1, tx1, rx1, ps1, done1, idx1, rb1};
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    check($sformatf("%s_rx10_t%0d", name, t), g0, e0);
    check($sformatf("%s_rx14_t%0d", name, t), g1, e1);
    if (log_idx >= 0 && log_idx < 64) log0[log_idx] = g0;
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    // Single-CPI checkpoints for the nominal instance: {cycle, busy,tx,rx,ps,done,idx,rb}.
    tbl[0]  = '{1,  '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0}};
    tbl[1]  = '{4,  '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0}};
    tbl[2]  = '{5,  '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0}};
    tbl[3]  = '{6,  '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0}};
    tbl[4]  = '{7,  '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 16'd0}};
    tbl[5]  = '{16, '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 16'd9}};
    tbl[6]  = '{17, '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0}};
    tbl[7]  = '{20, '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0}};
    tbl[8]  = '{21, '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 16'd0}};
    tbl[9]  = '{27, '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 16'd0}};
    tbl[10] = '{36, '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 16'd9}};
    tbl[11] = '{41, '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2, 16'd0}};
    tbl[12] = '{50, '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 16'd3}};
    tbl[13] = '{59, '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 16'd0}};
    tbl[14] = '{60, '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 16'd0}};
    tbl[15] = '{61, '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0}};
    for (int i = 0; i < 64; i++) log0[i] = '1;

    rst = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0;

    // Reset with start held, then idle.
    for (int k = 0; k < 4; k++) step("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1);
    for (int k = 0; k < 50; k++) step("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
    step("idle_abort_start", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, -1);

    // Single CPI, logged for the checkpoint table.
    for (int k = 0; k < 60; k++) step("single", 1'b1, (k == 0), 1'b0, 1'b0, 1'b1, k, k + 1);
    step("single_end", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 61);
    for (int i = 0; i < 16; i++) check($sformatf("table_cyc%0d", tbl[i].cyc), log0[tbl[i].cyc], tbl[i].e);

    // Continuous mode; cont dropped mid-CPI so the second CPI is the last.
    for (int k = 0; k < 120; k++) step("cont", 1'b1, (k == 0), (k < 70), 1'b0, 1'b1, k, -1);
    step("cont_end", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
    step("cont_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);

    // Abort mid-RX, then restart.
    for (int k = 0; k < 30; k++) step("abort_pre", 1'b1, (k == 0), 1'b0, 1'b0, 1'b1, k, -1);
    for (int k = 30; k < 35; k++) step("abort_idle", 1'b1, 1'b0, 1'b0, (k == 30), 1'b0, 0, -1);
    for (int k = 35; k < 95; k++) step("restart", 1'b1, (k == 35), 1'b0, 1'b0, 1'b1, k - 35, -1);
    step("restart_end", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);

    // Starts while busy are ignored; a start in the first idle cycle is accepted.
    for (int k = 0; k < 60; k++) step("busy_start", 1'b1, (k == 0 || k == 10), 1'b0, 1'b0, 1'b1, k, -1);
    step("busy_start_end", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1);
    for (int k = 0; k < 12; k++) step("after_busy", 1'b1, (k == 0), 1'b0, 1'b0, 1'b1, k, -1);

    // Reset mid-CPI behaves like abort.
    step("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
    for (int k = 0; k < 3; k++) step("rst_after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
